// File: rtl/speed_window_comparator.sv
// Registered G/Eq/L speed classifier with hysteresis band and persistence filter.
// Stage 1 classifies a against b, stage 2 debounces the class before it reaches the flags.
module speed_window_comparator #(
  parameter int WIDTH   = 8,
  parameter int HYST    = 2,
  parameter int PERSIST = 3,
  parameter int SIGNED  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             G,
  output logic             Eq,
  output logic             L,
  output logic             changed
);

  localparam int CW = $clog2(PERSIST + 1);

  localparam logic signed [WIDTH:0] HYST_P = (WIDTH+1)'(HYST);
  localparam logic signed [WIDTH:0] HYST_N = -HYST_P;
  localparam logic [CW:0]           PERSIST_C = (CW+1)'(PERSIST);

  typedef enum logic [1:0] {
    CLS_EQ = 2'd0,
    CLS_GT = 2'd1,
    CLS_LT = 2'd2
  } cls_e;

  logic signed [WIDTH:0] a_x;
  logic signed [WIDTH:0] b_x;
  logic signed [WIDTH:0] diff;
  cls_e                  raw_cls;

  logic    v1_q, v1_d;
  cls_e    raw_q, raw_d;
  cls_e    cls_q, cls_d;
  cls_e    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic    out_valid_q, out_valid_d;
  logic    changed_q, changed_d;

  // One extra bit keeps the difference exact for both operand modes.
  always_comb begin
    a_x = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
    b_x = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
    diff = a_x - b_x;
    raw_cls = CLS_EQ;
    if (diff > HYST_P) begin
      raw_cls = CLS_GT;
    end else if (diff < HYST_N) begin
      raw_cls = CLS_LT;
    end
  end

  always_comb begin
    v1_d        = in_valid;
    raw_d       = in_valid ? raw_cls : raw_q;
    cls_d       = cls_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    changed_d   = 1'b0;
    cnt_inc     = {1'b0, cnt_q} + (CW+1)'(1);

    if (clear) begin
      v1_d   = 1'b0;
      raw_d  = CLS_EQ;
      cls_d  = CLS_EQ;
      cand_d = CLS_EQ;
      cnt_d  = '0;
    end else if (v1_q) begin
      out_valid_d = 1'b1;
      if (raw_q == cls_q) begin
        cnt_d  = '0;
        cand_d = cls_q;
      end else if (raw_q == cand_q) begin
        if (cnt_inc >= PERSIST_C) begin
          cls_d     = raw_q;
          changed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end else begin
        cand_d = raw_q;
        if (PERSIST == 1) begin
          cls_d     = raw_q;
          changed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      raw_q       <= CLS_EQ;
      cls_q       <= CLS_EQ;
      cand_q      <= CLS_EQ;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      raw_q       <= raw_d;
      cls_q       <= cls_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      changed_q   <= changed_d;
    end
  end

  assign out_valid = out_valid_q;
  assign changed   = changed_q;
  assign G         = (cls_q == CLS_GT);
  assign Eq        = (cls_q == CLS_EQ);
  assign L         = (cls_q == CLS_LT);

endmodule

// File: doc/speed_window_comparator.md
Name: speed_window_comparator

Overview:
- Parametrised, registered successor of the 8-bit G/Eq/L magnitude comparator, used by the cruise controller to classify actual speed (a) against set speed (b).
- Adds a programmable hysteresis band, signed/unsigned mode, a valid handshake and a persistence filter. Output flags change only after a stable, repeated classification, so controller decisions do not chatter.
- Two-stage pipeline: stage 1 classifies, stage 2 filters.

Parameters:
- WIDTH, 8: operand width in bits.
- HYST, 2: equal-band half-width. |a-b| <= HYST classifies as Eq. HYST=0 gives an exact comparator.
- PERSIST, 3: number of consecutive valid samples of a new class required before the outputs switch. Must be >= 1.
- SIGNED, 0: 0 = unsigned operands, 1 = two's-complement operands.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush to the reset state.
- in_valid  in  1  a/b are valid this cycle.
- a  in  WIDTH  measured value.
- b  in  WIDTH  reference value.
- out_valid  out  1  one-cycle strobe; the sample entered 2 cycles earlier has been processed.
- G  out  1  filtered a > b+HYST.
- Eq  out  1  filtered |a-b| <= HYST.
- L  out  1  filtered a < b-HYST.
- changed  out  1  one-cycle pulse, coincident with out_valid, when the G/Eq/L class switches.

Behaviour:
- Reset (rst_n low, asynchronous) and clear (synchronous): G=0, Eq=1, L=0, out_valid=0, changed=0, stage-1 valid=0, candidate=EQ, count=0.
- clear has priority over in_valid in the same cycle; the sample is discarded and any in-flight stage-1 sample is flushed.
- Invariant: exactly one of G/Eq/L is high at all times, including during reset.
- Stage 1, on in_valid:
  - diff = a - b computed in WIDTH+1 bits; operands are zero-extended (SIGNED=0) or sign-extended (SIGNED=1). No wrap-around.
  - raw = GT if diff > HYST; LT if diff < -HYST; else EQ.
  - raw and a valid flag are registered.
- Stage 2 runs only when the stage-1 valid flag is set. Cycles with in_valid=0 are gaps and leave candidate and count untouched.
  - raw == current class: count <= 0, candidate <= current. No output change.
  - raw != current and raw == candidate: count <= count+1. On reaching PERSIST, outputs switch to raw, changed=1, count <= 0.
  - raw != current and raw != candidate: candidate <= raw, count <= 1. If PERSIST==1, switch immediately with changed=1.
  - out_valid=1 for every processed sample, whether or not a switch occurs.
- Latency: in_valid at cycle n gives out_valid and updated flags at cycle n+2. Throughput is one sample per cycle.
- A direct GT<->LT switch is allowed; it needs PERSIST samples of the new class and takes no detour through EQ.
- Count register width: clog2(PERSIST+1). Count never exceeds PERSIST.
- rst_n asserted mid-count: all state clears immediately without waiting for a clock edge. The first post-reset sample starts a fresh count.

Test Plan (WIDTH=8, HYST=2, PERSIST=3, SIGNED=0 unless stated):
- Reset/idle: hold rst_n low, then release with no in_valid -> G=0, Eq=1, L=0, out_valid=0, changed=0 on every cycle.
- Band: single sample a=100, b=102, then a=103, b=100 -> out_valid at n+2 and n+3, Eq stays 1, changed=0 (diff=-2 is in band; diff=3 only starts a count).
- Persistence with gaps: a=110, b=100 on three valid cycles separated by 2 idle cycles each -> first two out_valid show Eq. The third out_valid shows G=1, Eq=0, changed=1.
- Interrupted run: 110/100, 110/100, 100/100, 110/100, 110/100 -> Eq throughout, changed never asserted. One more 110/100 -> G=1, changed=1.
- Extremes/no wrap:
  - a=0, b=255, three samples -> L=1.
  - SIGNED=1, a=8'h80, b=8'h7F, three samples -> L=1.
  - SIGNED=1, a=8'h7F, b=8'h80, three samples -> G=1.
- Flush: two GT samples, clear together with a third GT sample -> Eq=1, out_valid=0 next cycle. Three further GT samples are needed to reach G.
- Async reset: drop rst_n mid-cycle while G=1 -> Eq=1 before the next clock edge.
